// File: rtl/accel_pkg.sv
// Shared definitions for the ReLU / max-pool ofmap writer.
// Holds the datapath widths, the writer FSM state type and the
// signed helper functions used by the ReLU/max datapath.
package accel_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rmp_state_e;

    // Signed maximum of two two's-complement samples.
    function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    // Clamp negative samples to zero when ReLU is enabled.
    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] d,
                                               input logic               en);
        return (en && d[DATA_W-1]) ? '0 : d;
    endfunction

endpackage

// File: rtl/relu_max_unit.sv
// Combinational ReLU followed by a signed running maximum.
// The first beat of a window starts a new maximum; later beats
// fold into the running value held by the caller.
module relu_max_unit
    import accel_pkg::*;
(
    input  logic              relu_en,
    input  logic              first,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] max_q,
    output logic [DATA_W-1:0] relu_val,
    output logic [DATA_W-1:0] run_max
);

    // Apply ReLU, then either restart or extend the window maximum.
    always_comb begin
        relu_val = relu(sample, relu_en);
        run_max  = first ? relu_val : smax(max_q, relu_val);
    end

endmodule

// File: rtl/relu_maxpool_writer.sv
// Downstream stage of the per-column accumulator: optional ReLU,
// optional 2x2 max-pool (groups of 4 beats), and registered writes
// into the ofmap SRAM write port.
//
// Input handshake: a beat is transferred on every cycle where
// in_valid_i is high; there is no ready, so the block never stalls
// the producer. Beats arriving outside RUN are dropped and flagged.
module relu_maxpool_writer
    import accel_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start_i,
    input  logic              cfg_pool_en_i,
    input  logic              cfg_relu_en_i,
    input  logic [ADDR_W-1:0] cfg_base_addr_i,
    input  logic              in_valid_i,
    input  logic              in_last_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    output logic              ofm_wren_o,
    output logic [ADDR_W-1:0] ofm_addr_o,
    output logic [DATA_W-1:0] ofm_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output rmp_state_e        dbg_state_o
);

    rmp_state_e        state;
    logic              pool_en_q;
    logic              relu_en_q;
    logic [ADDR_W-1:0] base_q;
    logic [1:0]        beat_cnt;
    logic [DATA_W-1:0] max_q;
    logic [ADDR_W-1:0] wr_cnt;
    logic [DATA_W-1:0] relu_val;
    logic [DATA_W-1:0] run_max;

    relu_max_unit u_relu_max (
        .relu_en  (relu_en_q),
        .first    (beat_cnt == 2'd0),
        .sample   (in_data_i),
        .max_q    (max_q),
        .relu_val (relu_val),
        .run_max  (run_max)
    );

    // Writer FSM, window counters and registered SRAM/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pool_en_q  <= 1'b0;
            relu_en_q  <= 1'b0;
            base_q     <= '0;
            beat_cnt   <= '0;
            max_q      <= '0;
            wr_cnt     <= '0;
            ofm_wren_o <= 1'b0;
            ofm_addr_o <= '0;
            ofm_data_o <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            ofm_wren_o <= 1'b0;
            done_o     <= 1'b0;
            if (cfg_start_i) begin
                // Start (or restart) a layer; any partial window is discarded.
                pool_en_q <= cfg_pool_en_i;
                relu_en_q <= cfg_relu_en_i;
                base_q    <= cfg_base_addr_i;
                beat_cnt  <= '0;
                max_q     <= '0;
                wr_cnt    <= '0;
                busy_o    <= 1'b1;
                state     <= RUN;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid_i) err_o <= 1'b1;
                    end
                    RUN: begin
                        if (in_valid_i) begin
                            if (pool_en_q) begin
                                max_q    <= run_max;
                                beat_cnt <= beat_cnt + 2'd1;
                                if (beat_cnt == 2'd3 || in_last_i) begin
                                    ofm_wren_o <= 1'b1;
                                    ofm_addr_o <= base_q + wr_cnt;
                                    ofm_data_o <= run_max;
                                    wr_cnt     <= wr_cnt + ADDR_W'(1);
                                end
                                if (in_last_i && beat_cnt != 2'd3) err_o <= 1'b1;
                            end else begin
                                ofm_wren_o <= 1'b1;
                                ofm_addr_o <= base_q + in_addr_i;
                                ofm_data_o <= relu_val;
                            end
                            if (in_last_i) state <= DONE;
                        end
                    end
                    DONE: begin
                        if (in_valid_i) err_o <= 1'b1;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign dbg_state_o = state;

endmodule

// File: tb/tb_relu_maxpool_writer.sv
// Directed bench for relu_maxpool_writer: hand-computed write
// sequences are queued as {addr,data} and matched against every
// ofm_wren_o pulse; status outputs are checked at fixed cycles.
module tb_relu_maxpool_writer;
    import accel_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              cfg_start_i;
    logic              cfg_pool_en_i;
    logic              cfg_relu_en_i;
    logic [ADDR_W-1:0] cfg_base_addr_i;
    logic              in_valid_i;
    logic              in_last_i;
    logic [DATA_W-1:0] in_data_i;
    logic [ADDR_W-1:0] in_addr_i;
    logic              ofm_wren_o;
    logic [ADDR_W-1:0] ofm_addr_o;
    logic [DATA_W-1:0] ofm_data_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    rmp_state_e        dbg_state_o;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    relu_maxpool_writer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_start_i     (cfg_start_i),
        .cfg_pool_en_i   (cfg_pool_en_i),
        .cfg_relu_en_i   (cfg_relu_en_i),
        .cfg_base_addr_i (cfg_base_addr_i),
        .in_valid_i      (in_valid_i),
        .in_last_i       (in_last_i),
        .in_data_i       (in_data_i),
        .in_addr_i       (in_addr_i),
        .ofm_wren_o      (ofm_wren_o),
        .ofm_addr_o      (ofm_addr_o),
        .ofm_data_o      (ofm_data_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .dbg_state_o     (dbg_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every write pulse must match the head of exp_q
    always @(negedge clk) begin
        if (ofm_wren_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", 32'(ofm_wren_o), 32'd0);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = exp_q.pop_front();
                check_eq("wr_addr", 32'(ofm_addr_o), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                check_eq("wr_data", 32'(ofm_data_o), 32'(e[DATA_W-1:0]));
            end
        end
    end

    // driver tasks: all called at a negedge, return at a negedge
    task automatic do_start(input logic pool, input logic relu_on, input logic [ADDR_W-1:0] base);
        cfg_start_i     = 1'b1;
        cfg_pool_en_i   = pool;
        cfg_relu_en_i   = relu_on;
        cfg_base_addr_i = base;
        @(negedge clk);
        cfg_start_i = 1'b0;
    endtask

    task automatic beat(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a, input logic last);
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_addr_i  = a;
        in_last_i  = last;
        @(negedge clk);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; cfg_start_i = 1'b0; cfg_pool_en_i = 1'b0; cfg_relu_en_i = 1'b0;
        cfg_base_addr_i = '0; in_valid_i = 1'b0; in_last_i = 1'b0; in_data_i = '0; in_addr_i = '0;

        // 1: reset held 4 cycles with in_valid toggling
        repeat (4) begin
            @(negedge clk);
            in_valid_i = ~in_valid_i;
        end
        check_eq("rst_wren", 32'(ofm_wren_o), 32'd0);
        check_eq("rst_addr", 32'(ofm_addr_o), 32'd0);
        check_eq("rst_data", 32'(ofm_data_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_err",  32'(err_o),  32'd0);
        check_eq("rst_state", 32'(dbg_state_o), 32'(IDLE));
        in_valid_i = 1'b0;
        rst_n = 1'b1;
        idle(1);

        // 2: pool + ReLU, base 0x100
        do_start(1'b1, 1'b1, 10'h100);
        check_eq("t2_busy_start", 32'(busy_o), 32'd1);
        expect_wr(10'h100, 8'h07);
        expect_wr(10'h101, 8'h00);
        beat(8'hFB, 0, 0); beat(8'h03, 0, 0); beat(8'h07, 0, 0); beat(8'h80, 0, 0);
        beat(8'hFF, 0, 0); beat(8'hFE, 0, 0); beat(8'hFD, 0, 0); beat(8'hFC, 0, 1);
        // now in the cycle of the second write
        check_eq("t2_wr_cycle_done", 32'(done_o), 32'd0);
        check_eq("t2_wr_cycle_busy", 32'(busy_o), 32'd1);
        idle(1);
        check_eq("t2_done_pulse", 32'(done_o), 32'd1);
        check_eq("t2_busy_fall",  32'(busy_o), 32'd0);
        check_eq("t2_hold_addr",  32'(ofm_addr_o), 32'h101);
        idle(1);
        check_eq("t2_done_end", 32'(done_o), 32'd0);

        // 3: pool, ReLU off, signed compare
        do_start(1'b1, 1'b0, 10'h020);
        expect_wr(10'h020, 8'hFD);
        expect_wr(10'h021, 8'h7F);
        beat(8'hFB, 0, 0); beat(8'hFD, 0, 0); beat(8'hF9, 0, 0); beat(8'h80, 0, 0);
        beat(8'h7F, 0, 0); beat(8'h80, 0, 0); beat(8'h00, 0, 0); beat(8'h01, 0, 1);
        idle(3);

        // 4: bypass, ReLU on, address wrap
        do_start(1'b0, 1'b1, 10'h3FE);
        expect_wr(10'h3FF, 8'h00);
        expect_wr(10'h000, 8'h14);
        beat(8'hF7, 10'd1, 0);
        beat(8'h14, 10'd2, 1);
        idle(3);
        check_eq("t4_err_clear", 32'(err_o), 32'd0);

        // 5: pool, last on 6th beat -> partial window, sticky error
        do_start(1'b1, 1'b0, 10'h040);
        expect_wr(10'h040, 8'h04);
        expect_wr(10'h041, 8'h09);
        beat(8'h01, 0, 0); beat(8'h02, 0, 0); beat(8'h03, 0, 0); beat(8'h04, 0, 0);
        beat(8'h09, 0, 0); beat(8'hFE, 0, 1);
        check_eq("t5_err_set", 32'(err_o), 32'd1);
        idle(2);
        do_start(1'b1, 1'b0, 10'h000);
        idle(2);
        check_eq("t5_err_sticky", 32'(err_o), 32'd1);
        do_reset();
        check_eq("t5_err_reset", 32'(err_o), 32'd0);
        check_eq("t5_busy_reset", 32'(busy_o), 32'd0);

        // 6: abort mid-window, then stray beat in IDLE
        do_start(1'b1, 1'b0, 10'h050);
        beat(8'h11, 0, 0); beat(8'h22, 0, 0);
        do_start(1'b1, 1'b0, 10'h050);
        check_eq("t6_no_abort_wr", 32'(ofm_wren_o), 32'd0);
        expect_wr(10'h050, 8'h08);
        beat(8'h08, 0, 0); beat(8'hFF, 0, 0); beat(8'h03, 0, 0); beat(8'h02, 0, 1);
        idle(3);
        check_eq("t6_err_before", 32'(err_o), 32'd0);
        beat(8'h05, 0, 0);
        check_eq("t6_err_idle_beat", 32'(err_o), 32'd1);
        check_eq("t6_no_idle_wr", 32'(ofm_wren_o), 32'd0);
        idle(3);

        check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
